sprite_renderer_gen: RTL and testbench
======================================

SPRITE_RENDERER_GEN -- requirements
Module: sprite_renderer_gen

Interface
REQ-001 SHALL have parameter W, default 16, sprite width in pixels (multiple of 8, range 8..64).
REQ-002 SHALL have parameter H, default 16, sprite height in scanlines (power of 2, range 2..64).
REQ-003 SHALL have parameter AW, default clog2(H)+clog2(W/8), ROM address width.
REQ-004 clk  input  1  pixel clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 vstart  input  1  pulse; sprite top row begins on this scanline.
REQ-007 load  input  1  scanline fetch trigger (hsync).
REQ-008 hstart  input  1  pulse; first sprite pixel column.
REQ-009 hmirror  input  1  mirror left/right; sampled every DRAW cycle.
REQ-010 vmirror  input  1  mirror top/bottom; sampled at each fetch.
REQ-011 rom_addr  output  AW  registered address {row, byte index}.
REQ-012 rom_bits  input  8  combinational ROM data for rom_addr.
REQ-013 gfx  output  1  registered pixel output.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, WAIT_LOAD, FETCH_SETUP, FETCH_DATA, WAIT_HSTART, DRAW.
REQ-016 IDLE: ycount<=0; vstart -> WAIT_LOAD; other inputs ignored.
REQ-017 WAIT_LOAD: xcount<=0, bcount<=0; load -> FETCH_SETUP.
REQ-018 FETCH_SETUP: rom_addr <= {vmirror ? H-1-row : row, bcount}; -> FETCH_DATA.
REQ-019 FETCH_DATA: line buffer byte bcount <= rom_bits; bcount==W/8-1 -> WAIT_HSTART, else bcount+1 and -> FETCH_SETUP.
REQ-020 Line fetch latency SHALL be exactly 2*(W/8) cycles after load is seen.
REQ-021 WAIT_HSTART: hstart -> DRAW; hstart during fetch states SHALL be ignored (pixel line lost, not deferred).
REQ-022 DRAW: gfx <= buf[hmirror ? W-1-xcount : xcount]; buffer bit n is pixel column n, byte k holds columns 8k..8k+7.
REQ-023 First gfx pixel SHALL appear the cycle after the first DRAW cycle; exactly W gfx cycles per line.
REQ-024 On last column: if row==H-1 -> IDLE, else row+1 and -> WAIT_LOAD.
REQ-025 gfx SHALL be 0 in every cycle not following a DRAW cycle.
REQ-026 vstart while busy SHALL be ignored; sprite completes unchanged.
REQ-027 load in WAIT_HSTART or DRAW SHALL be ignored.
REQ-028 xcount, ycount, bcount SHALL be sized to exactly hold W-1, H-1, W/8-1; no wrap beyond terminal values.

Reset
REQ-029 reset SHALL immediately force state IDLE, gfx 0, busy 0, rom_addr 0, all counters and line buffer 0.
REQ-030 reset asserted mid-line or mid-fetch SHALL abort the sprite; after release the block waits for a new vstart.

Configuration
REQ-031 Macro SPRITE_SCALE2X_EN defined: each pixel SHALL be output for 2 consecutive cycles (2W gfx cycles/line) and each ROM row SHALL be drawn on 2 consecutive scanlines (2H lines per sprite, row = line count >> 1, refetched each line).
REQ-032 Macro undefined: 1x scaling, W cycles per line, H lines per sprite; no scaling logic present.

Verification
REQ-033 W=16,H=16, row0 bytes 0x01,0x80; vstart, load, hstart -> gfx high at pixels 0 and 15 only, rom_addr 0 then 1, busy high.
REQ-034 Same row, hmirror=1 -> gfx pattern unchanged (symmetric); row0 bytes 0x03,0x00 -> gfx high at pixels 14,15 only.
REQ-035 vmirror=1, 16 lines -> first fetched address 0x1E, last 0x00; busy drops after 16th line's last pixel.
REQ-036 W=32: load -> 8 fetch cycles, rom_addr sequence {row,0..3}; hstart at fetch cycle 4 ignored, gfx stays 0 that line.
REQ-037 reset pulsed at DRAW pixel 7 of row 5 -> gfx 0 and busy 0 same cycle; next vstart restarts at row 0.
REQ-038 SPRITE_SCALE2X_EN defined, W=16,H=16: row0 0x01,0x00 -> gfx high 2 cycles on scanlines 0 and 1; busy for 32 lines.

Source files
------------

// File: rtl/sprite_renderer_gen.sv
// Scanline sprite renderer: fetches one ROM row into a line buffer per hsync, then shifts it out on gfx.
// Define SPRITE_SCALE2X_EN to draw every pixel for two cycles and every ROM row on two scanlines.
module sprite_renderer_gen #(
    parameter int W  = 16,
    parameter int H  = 16,
    parameter int AW = $clog2(H) + $clog2(W / 8)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vstart,
    input  logic          load,
    input  logic          hstart,
    input  logic          hmirror,
    input  logic          vmirror,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_bits,
    output logic          gfx,
    output logic          busy
);

    localparam int NB  = W / 8;
    localparam int XW  = $clog2(W);
    localparam int BIW = $clog2(NB);
    localparam int BW  = (BIW > 0) ? BIW : 1;
    localparam int RW  = $clog2(H);
`ifdef SPRITE_SCALE2X_EN
    localparam int YW  = RW + 1;
    localparam int SC  = 2;
`else
    localparam int YW  = RW;
    localparam int SC  = 1;
`endif
    localparam int YMAX = H * SC - 1;

    typedef enum logic [2:0] {
        IDLE, WAIT_LOAD, FETCH_SETUP, FETCH_DATA, WAIT_HSTART, DRAW
    } state_t;

    state_t         state, state_next;
    logic [XW-1:0]  xcount;
    logic [YW-1:0]  ycount;
    logic [BW-1:0]  bcount;
    logic [W-1:0]   lbuf;
    logic [RW-1:0]  row, row_eff;
    logic [XW-1:0]  pix_idx;
    logic           x_step, last_x, last_b, last_y, line_end;

`ifdef SPRITE_SCALE2X_EN
    // phase=1 marks the second cycle of a doubled pixel; the column only advances then
    logic phase;
    assign row    = ycount[YW-1:1];
    assign x_step = phase;
`else
    assign row    = ycount;
    assign x_step = 1'b1;
`endif

    assign row_eff  = vmirror ? (RW'(H - 1) - row) : row;
    assign pix_idx  = hmirror ? (XW'(W - 1) - xcount) : xcount;
    assign last_x   = (xcount == XW'(W - 1));
    assign last_b   = (bcount == BW'(NB - 1));
    assign last_y   = (ycount == YW'(YMAX));
    assign line_end = last_x && x_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (vstart) state_next = WAIT_LOAD;
            WAIT_LOAD:   if (load)   state_next = FETCH_SETUP;
            FETCH_SETUP: state_next = FETCH_DATA;
            FETCH_DATA:  state_next = last_b ? WAIT_HSTART : FETCH_SETUP;
            WAIT_HSTART: if (hstart) state_next = DRAW;
            DRAW:        if (line_end) state_next = last_y ? IDLE : WAIT_LOAD;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            gfx      <= 1'b0;
            xcount   <= '0;
            ycount   <= '0;
            bcount   <= '0;
            lbuf     <= '0;
`ifdef SPRITE_SCALE2X_EN
            phase    <= 1'b0;
`endif
        end else begin
            gfx <= 1'b0;
            case (state)
                IDLE: ycount <= '0;
                WAIT_LOAD: begin
                    xcount <= '0;
                    bcount <= '0;
`ifdef SPRITE_SCALE2X_EN
                    phase  <= 1'b0;
`endif
                end
                FETCH_SETUP: rom_addr <= (AW'(row_eff) << BIW) | AW'(bcount);
                FETCH_DATA: begin
                    for (int k = 0; k < NB; k++)
                        if (bcount == BW'(k)) lbuf[8*k +: 8] <= rom_bits;
                    if (!last_b) bcount <= bcount + 1'b1;
                end
                DRAW: begin
                    gfx <= lbuf[pix_idx];
`ifdef SPRITE_SCALE2X_EN
                    phase <= ~phase;
`endif
                    if (x_step && !last_x) xcount <= xcount + 1'b1;
                    if (line_end && !last_y) ycount <= ycount + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_renderer_gen.sv
// Directed bench for sprite_renderer_gen: a 16x16 instance for line/sprite checks and a 32-wide one for fetch timing.
module tb_sprite_renderer_gen;
`ifdef SPRITE_SCALE2X_EN
    localparam int SC = 2;
`else
    localparam int SC = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vstart = 0, load = 0, hstart = 0, hmirror = 0, vmirror = 0;
    logic [4:0] rom_addr;
    logic [7:0] rom_bits;
    logic       gfx, busy;
    logic       vstart32 = 0, load32 = 0, hstart32 = 0;
    logic [5:0] rom_addr32;
    logic [7:0] rom_bits32;
    logic       gfx32, busy32;

    logic [7:0] rom   [0:31];
    logic [7:0] rom32 [0:63];
    assign rom_bits   = rom[rom_addr];
    assign rom_bits32 = rom32[rom_addr32];

    always #5 clk = ~clk;

    sprite_renderer_gen #(.W(16), .H(16)) u_dut (
        .clk(clk), .reset(reset), .vstart(vstart), .load(load), .hstart(hstart),
        .hmirror(hmirror), .vmirror(vmirror), .rom_addr(rom_addr), .rom_bits(rom_bits),
        .gfx(gfx), .busy(busy)
    );

    sprite_renderer_gen #(.W(32), .H(16)) u_dut32 (
        .clk(clk), .reset(reset), .vstart(vstart32), .load(load32), .hstart(hstart32),
        .hmirror(1'b0), .vmirror(1'b0), .rom_addr(rom_addr32), .rom_bits(rom_bits32),
        .gfx(gfx32), .busy(busy32)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Stretch a 16-pixel pattern to the time domain of the configured scale
    function automatic logic [31:0] expand(input logic [15:0] p);
        logic [31:0] e = '0;
        for (int t = 0; t < 16 * SC; t++) e[t] = p[t / SC];
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic pulse_vstart();
        @(negedge clk) vstart = 1'b1;
        @(negedge clk) vstart = 1'b0;
    endtask

    // Returns at the negedge where the DUT sits in WAIT_HSTART; optionally pulses load there.
    task automatic fetch_line(input logic vm, input logic ld_extra,
                              output logic [7:0] a0, output logic [7:0] a1);
        vmirror = vm;
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
        @(negedge clk) a0 = {3'b0, rom_addr};
        @(negedge clk);
        @(negedge clk) a1 = {3'b0, rom_addr};
        @(negedge clk);
        if (ld_extra) begin
            load = 1'b1;
            @(negedge clk) load = 1'b0;
        end
    endtask

    task automatic draw_line(input logic hm, output logic [31:0] pat, output logic tail);
        hmirror = hm;
        hstart = 1'b1;
        @(negedge clk) hstart = 1'b0;
        pat = '0;
        for (int t = 0; t < 16 * SC; t++) begin
            @(negedge clk);
            pat[t] = gfx;
        end
        @(negedge clk) tail = gfx;
    endtask

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        hm;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [7];

    logic [7:0]  a0, a1;
    logic [31:0] pat;
    logic        tail, acc;
    int          ones;

    initial begin
        vecs[0] = '{8'h01, 8'h80, 1'b0, 16'h8001};
        vecs[1] = '{8'h01, 8'h80, 1'b1, 16'h8001};
        vecs[2] = '{8'h03, 8'h00, 1'b1, 16'hC000};
        vecs[3] = '{8'h03, 8'h00, 1'b0, 16'h0003};
        vecs[4] = '{8'hF0, 8'h0F, 1'b0, 16'h0FF0};
        vecs[5] = '{8'h12, 8'h34, 1'b1, 16'h482C};
        vecs[6] = '{8'hA5, 8'h5A, 1'b0, 16'h5AA5};
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        for (int i = 0; i < 64; i++) rom32[i] = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            rom[2*i]   = vecs[i].b0;
            rom[2*i+1] = vecs[i].b1;
        end

        do_reset();
        check("reset_gfx", {31'b0, gfx}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_addr", {27'b0, rom_addr}, 0);

        // Table rows: one ROM row per table entry, drawn on consecutive scanlines
        pulse_vstart();
        check("busy_after_vstart", {31'b0, busy}, 1);
        for (int l = 0; l < 7 * SC; l++) begin
            fetch_line(1'b0, l == 3 * SC, a0, a1);
            draw_line(vecs[l / SC].hm, pat, tail);
            check($sformatf("vec%0d_addr0", l), {24'b0, a0}, 32'(2 * (l / SC)));
            check($sformatf("vec%0d_addr1", l), {24'b0, a1}, 32'(2 * (l / SC) + 1));
            check($sformatf("vec%0d_gfx", l), pat, expand(vecs[l / SC].exp));
            check($sformatf("vec%0d_tail", l), {31'b0, tail}, 0);
        end

        // Vertical mirror through a whole sprite, with a stray vstart mid-sprite
        do_reset();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[30] = 8'h01;
        rom[1]  = 8'h80;
        pulse_vstart();
        for (int l = 0; l < 16 * SC; l++) begin
            if (l == 5) pulse_vstart();
            if (l == 16 * SC - 1) check("vm_busy_before_last", {31'b0, busy}, 1);
            fetch_line(1'b1, 1'b0, a0, a1);
            draw_line(1'b0, pat, tail);
            if (l == 0) begin
                check("vm_first_addr", {24'b0, a0}, 32'h1E);
                check("vm_first_gfx", pat, expand(16'h0001));
            end
            if (l == 16 * SC - 1) begin
                check("vm_last_line_addr0", {24'b0, a0}, 32'h00);
                check("vm_last_line_addr1", {24'b0, a1}, 32'h01);
                check("vm_last_gfx", pat, expand(16'h8000));
                check("vm_busy_after_last", {31'b0, busy}, 0);
            end
        end

        // Reset during pixel 7 of row 5 aborts the sprite at once
        do_reset();
        vmirror = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0]  = 8'h81;
        rom[10] = 8'hFF;
        rom[11] = 8'hFF;
        pulse_vstart();
        for (int l = 0; l < 5 * SC; l++) begin
            fetch_line(1'b0, 1'b0, a0, a1);
            draw_line(1'b0, pat, tail);
        end
        fetch_line(1'b0, 1'b0, a0, a1);
        check("row5_addr", {24'b0, a0}, 32'h0A);
        hstart = 1'b1;
        @(negedge clk) hstart = 1'b0;
        for (int t = 0; t < 8; t++) @(negedge clk);
        check("row5_px7_gfx", {31'b0, gfx}, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_gfx", {31'b0, gfx}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_addr", {27'b0, rom_addr}, 0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {31'b0, busy}, 0);
        pulse_vstart();
        fetch_line(1'b0, 1'b0, a0, a1);
        draw_line(1'b0, pat, tail);
        check("restart_addr", {24'b0, a0}, 0);
        check("restart_gfx", pat, expand(16'h0081));

        // W=32: eight fetch cycles, hstart during fetch is dropped
        do_reset();
        @(negedge clk) vstart32 = 1'b1;
        @(negedge clk) vstart32 = 1'b0;
        @(negedge clk) load32 = 1'b1;
        @(negedge clk) load32 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) hstart32 = 1'b1;
            if (c == 4) hstart32 = 1'b0;
            if (c % 2 == 1) check($sformatf("w32_addr%0d", c / 2), {26'b0, rom_addr32}, 32'(c / 2));
        end
        acc = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            acc = acc | gfx32;
        end
        check("w32_hstart_in_fetch_dropped", {31'b0, acc}, 0);
        check("w32_busy", {31'b0, busy32}, 1);
        hstart32 = 1'b1;
        @(negedge clk) hstart32 = 1'b0;
        ones = 0;
        for (int t = 0; t < 32 * SC + 4; t++) begin
            @(negedge clk);
            ones += int'(gfx32);
        end
        check("w32_pixel_count", 32'(ones), 32'(32 * SC));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
